run_controller: RTL and testbench

//  Synthesisable successor to the bench-level reset/run sequence: it holds NUM_CORES cores in reset,

---
 rtl/run_ctrl_pkg.sv | 20 ++
 rtl/run_controller.sv | 123 ++++++++++++
 tb/tb_run_controller.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and sizing helpers for the core reset/run sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  // Hold-counter value at which the last core is released (and RUN begins).
  function automatic int hold_last(input int reset_cycles, input int num_cores, input int stagger);
    return reset_cycles + (num_cores - 1) * stagger;
  endfunction

  function automatic int hold_cnt_width(input int reset_cycles, input int num_cores, input int stagger);
    return $clog2(hold_last(reset_cycles, num_cores, stagger) + 1);
  endfunction

endpackage

// File: rtl/run_controller.sv
// Holds the cores in reset, releases them (optionally staggered), bounds the run
// to MAX_CYCLES and reports whether all cores halted or the budget ran out.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int NUM_CORES    = 2,
  parameter int RESET_CYCLES = 2,
  parameter int STAGGER      = 0,
  parameter int MAX_CYCLES   = 1000,
  parameter int CNT_W        = $clog2(MAX_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [NUM_CORES-1:0] halt_i,
  output logic [NUM_CORES-1:0] core_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [NUM_CORES-1:0] halted,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int HOLD_LAST = hold_last(RESET_CYCLES, NUM_CORES, STAGGER);
  localparam int HOLD_W    = hold_cnt_width(RESET_CYCLES, NUM_CORES, STAGGER);

  run_state_t            state_q;
  logic [HOLD_W-1:0]     hold_cnt_q;
  logic [NUM_CORES-1:0]  core_reset_q;
  logic                  running_q;
  logic                  done_q;
  logic                  timeout_q;
  logic [NUM_CORES-1:0]  halted_q;
  logic [CNT_W-1:0]      cycle_cnt_q;

  logic [HOLD_W-1:0]     hold_cnt_d;
  logic [NUM_CORES-1:0]  release_hit;
  logic [NUM_CORES-1:0]  halted_d;
  logic [CNT_W-1:0]      cycle_cnt_d;
  logic                  budget_last;

  // Value the hold counter takes at this edge; never exceeds HOLD_LAST while in HOLD.
  assign hold_cnt_d = hold_cnt_q + HOLD_W'(1);

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_release
    localparam logic [HOLD_W-1:0] REL_AT = HOLD_W'(RESET_CYCLES + gi * STAGGER);
    assign release_hit[gi] = (hold_cnt_d >= REL_AT);
  end

  // Cores still in reset cannot report a halt.
  assign halted_d    = halted_q | (halt_i & ~core_reset_q);
  assign cycle_cnt_d = (cycle_cnt_q == CNT_W'(MAX_CYCLES)) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
  assign budget_last = (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      core_reset_q <= '1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      halted_q     <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          core_reset_q <= '1;
          if (start) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
          end
        end
        HOLD: begin
          hold_cnt_q   <= hold_cnt_d;
          core_reset_q <= ~release_hit;
          if (hold_cnt_d == HOLD_W'(HOLD_LAST)) begin
            state_q     <= RUN;
            running_q   <= 1'b1;
            cycle_cnt_q <= '0;
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          halted_q    <= halted_d;
          // A full halt mask wins over budget exhaustion on the same edge.
          if (&halted_d) begin
            state_q      <= DONE;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            timeout_q    <= 1'b0;
            core_reset_q <= '1;
          end else if (budget_last) begin
            state_q      <= DONE;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            timeout_q    <= 1'b1;
            core_reset_q <= '1;
          end
        end
        DONE: begin
          if (clear) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            halted_q    <= '0;
            cycle_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench: a default-configured controller plus a 4-core staggered one.
module tb_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, clear_a;
  logic [1:0] halt_a;
  logic [1:0] core_reset_a, halted_a;
  logic       running_a, done_a, timeout_a;
  logic [9:0] cc_a;

  logic       start_b, clear_b;
  logic [3:0] halt_b;
  logic [3:0] core_reset_b, halted_b;
  logic       running_b, done_b, timeout_b;
  logic [9:0] cc_b;

  int n_checks = 0;
  int n_errors = 0;

  run_controller u_dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .clear(clear_a), .halt_i(halt_a),
    .core_reset(core_reset_a), .running(running_a), .done(done_a), .timeout(timeout_a),
    .halted(halted_a), .cycle_count(cc_a)
  );

  run_controller #(.NUM_CORES(4), .RESET_CYCLES(2), .STAGGER(3), .MAX_CYCLES(1000)) u_dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .clear(clear_b), .halt_i(halt_b),
    .core_reset(core_reset_b), .running(running_b), .done(done_b), .timeout(timeout_b),
    .halted(halted_b), .cycle_count(cc_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_a_done(input string tag, input logic exp_to, input logic [9:0] exp_cc,
                            input logic [1:0] exp_halted);
    chk({tag, "_done"}, 64'(done_a), 64'd1);
    chk({tag, "_running"}, 64'(running_a), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_a), 64'(exp_to));
    chk({tag, "_cc"}, 64'(cc_a), 64'(exp_cc));
    chk({tag, "_halted"}, 64'(halted_a), 64'(exp_halted));
    chk({tag, "_core_reset"}, 64'(core_reset_a), 64'h3);
  endtask

  task automatic chk_a_idle(input string tag);
    chk({tag, "_core_reset"}, 64'(core_reset_a), 64'h3);
    chk({tag, "_running"}, 64'(running_a), 64'd0);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout_a), 64'd0);
    chk({tag, "_halted"}, 64'(halted_a), 64'd0);
    chk({tag, "_cc"}, 64'(cc_a), 64'd0);
  endtask

  // Start pulse at E0, two hold edges, halt during run cycle 10 -> done with count 10.
  task automatic run_scenario1(input string tag);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk({tag, "_e0_core_reset"}, 64'(core_reset_a), 64'h3);
    chk({tag, "_e0_running"}, 64'(running_a), 64'd0);
    tick();
    chk({tag, "_e1_core_reset"}, 64'(core_reset_a), 64'h3);
    tick();
    chk({tag, "_e2_core_reset"}, 64'(core_reset_a), 64'h0);
    chk({tag, "_e2_running"}, 64'(running_a), 64'd1);
    chk({tag, "_e2_cc"}, 64'(cc_a), 64'd0);
    for (int i = 0; i < 9; i++) tick();
    chk({tag, "_cc9"}, 64'(cc_a), 64'd9);
    chk({tag, "_cc9_done"}, 64'(done_a), 64'd0);
    halt_a = 2'b11;
    tick();
    halt_a = 2'b00;
    chk_a_done({tag, "_halt"}, 1'b0, 10'd10, 2'b11);
  endtask

  task automatic start_to_run_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [3:0] exp_cr;
    rst_n   = 1'b0;
    start_a = 1'b0; clear_a = 1'b0; halt_a = 2'b00;
    start_b = 1'b0; clear_b = 1'b0; halt_b = 4'b0000;
    tick();
    tick();
    chk_a_idle("reset_a");
    chk("reset_b_core_reset", 64'(core_reset_b), 64'hf);
    chk("reset_b_running", 64'(running_b), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_core_reset", 64'(core_reset_a), 64'h3);

    // Scenario 1: halt at run cycle 10
    run_scenario1("s1");

    // Scenario 6: start ignored in DONE, clear returns to IDLE
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk_a_done("s6_start_ignored", 1'b0, 10'd10, 2'b11);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    chk_a_idle("s6_cleared");

    // Scenario 2: budget exhaustion
    start_to_run_a();
    chk("s2_running", 64'(running_a), 64'd1);
    for (int i = 0; i < 999; i++) tick();
    chk("s2_cc999", 64'(cc_a), 64'd999);
    chk("s2_cc999_done", 64'(done_a), 64'd0);
    tick();
    chk_a_done("s2_timeout", 1'b1, 10'd1000, 2'b00);
    // Frozen in DONE
    tick();
    chk("s2_frozen_cc", 64'(cc_a), 64'd1000);

    // Simultaneous start+clear in DONE: clear wins, no sequence starts
    start_a = 1'b1; clear_a = 1'b1;
    tick();
    start_a = 1'b0; clear_a = 1'b0;
    chk_a_idle("startclear");
    tick();
    tick();
    chk("startclear_no_release", 64'(core_reset_a), 64'h3);
    chk("startclear_no_run", 64'(running_a), 64'd0);

    // Scenario 4: halt on the final budget cycle wins
    start_to_run_a();
    for (int i = 0; i < 999; i++) tick();
    chk("s4_cc999", 64'(cc_a), 64'd999);
    halt_a = 2'b11;
    tick();
    halt_a = 2'b00;
    chk_a_done("s4_tie", 1'b0, 10'd1000, 2'b11);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;

    // Scenario 5: reset mid-run, then scenario 1 repeats exactly
    start_to_run_a();
    for (int i = 0; i < 50; i++) tick();
    chk("s5_cc50", 64'(cc_a), 64'd50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_a_idle("s5_reset");
    run_scenario1("s5_rerun");

    // Scenario 3: four cores, stagger 3
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      for (int i = 0; i < 4; i++) exp_cr[i] = (k < 2 + 3 * i);
      chk($sformatf("s3_core_reset_e%0d", k), 64'(core_reset_b), 64'(exp_cr));
      chk($sformatf("s3_running_e%0d", k), 64'(running_b), 64'(k >= 11));
      if (k == 5) halt_b = 4'b1000;
      if (k == 6) halt_b = 4'b0000;
    end
    tick();
    tick();
    tick();
    chk("s3_halt3_ignored", 64'(halted_b), 64'h0);
    chk("s3_cc3", 64'(cc_b), 64'd3);
    halt_b = 4'b0111;
    tick();
    halt_b = 4'b1000;
    chk("s3_partial_halted", 64'(halted_b), 64'h7);
    chk("s3_partial_done", 64'(done_b), 64'd0);
    tick();
    halt_b = 4'b0000;
    chk("s3_done", 64'(done_b), 64'd1);
    chk("s3_timeout", 64'(timeout_b), 64'd0);
    chk("s3_halted", 64'(halted_b), 64'hf);
    chk("s3_cc", 64'(cc_b), 64'd5);
    chk("s3_core_reset_done", 64'(core_reset_b), 64'hf);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
